rr_object_arbiter: RTL and testbench
====================================

// Module: rr_object_arbiter
// PURPOSE
//  Round-robin arbiter sharing one sequential resource (object renderer / object RAM port)
//  between N_REQ active-high requesters (player sub, enemy subs, sharks, divers, torpedoes).
//  Picks the lowest-index request at or above a rotating pointer with a low-first priority
//  search, wrapping to index 0, then holds the grant until done, request drop or timeout.
//  Sits between the per-object FSMs and the shared frame-draw datapath.
// PARAMETERS
//  N_REQ     8   number of requesters (2..32)
//  IDX_W     3   width of grant index; 2**IDX_W >= N_REQ
//  MAX_HOLD  15  max cycles a grant is held in BUSY before forced release (1..2**HOLD_W-1)
//  HOLD_W    4   width of hold counter
// PORTS
//  clk          in   1       system clock, rising edge
//  rst          in   1       asynchronous reset, active-high
//  req          in   N_REQ   request vector, bit i = requester i, active-high, level
//  done         in   1       resource finished current job; sampled only in BUSY
//  grant        out  N_REQ   one-hot grant, registered; all-zero when not BUSY
//  grant_idx    out  IDX_W   binary index of granted requester; 0 when not BUSY
//  grant_valid  out  1       high exactly while in BUSY
//  timeout      out  1       one-cycle pulse on forced release after MAX_HOLD cycles
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, ptr=0, hold_cnt=0, all outputs 0.
//  States: IDLE -> BUSY -> GAP -> IDLE. All outputs registered.
//  IDLE: masked = req & ~((1<<ptr)-1). If masked!=0 pick lowest set bit of masked, else
//   lowest set bit of req. If req!=0: next edge BUSY, grant/grant_idx = pick, hold_cnt=0.
//   req==0: stay IDLE. Latency: req seen at edge k -> grant_valid high after edge k.
//  BUSY: hold_cnt += 1 per cycle (saturating at MAX_HOLD). Release conditions, priority:
//   1) done=1 -> GAP, no timeout.
//   2) req[grant_idx]=0 (requester abort) -> GAP, no timeout.
//   3) hold_cnt==MAX_HOLD-1 and neither above -> GAP, timeout=1 for the GAP cycle.
//   done and timeout coinciding: done wins. Changes on other req bits ignored.
//  GAP: one cycle, grant=0, grant_valid=0, grant_idx=0; ptr <= (granted_idx+1) mod N_REQ
//   (wrap N_REQ-1 -> 0). Next edge IDLE. GAP guarantees one idle cycle between grants.
//  Fairness: a continuously requesting master waits at most N_REQ-1 grants.
//  Width rule: ptr and grant_idx are IDX_W bits; indices >= N_REQ never produced.
//  rst mid-BUSY: grant drops immediately, ptr returns to 0, no timeout pulse.
// TESTING
//  T1 reset: rst=1 with req=8'hFF -> grant=0, grant_valid=0, timeout=0; release -> grant=8'h01.
//  T2 rotation: req=8'hFF, done pulsed 2 cycles after each grant -> grant_idx 0,1,..,7,0;
//     grant_valid low exactly one cycle between grants.
//  T3 wrap/skip: ptr=6 (after grant to 5), req=8'b0000_1010 -> grant_idx=1, then ptr=2 -> idx 3.
//  T4 timeout: req=8'h04 held, done=0 -> grant_idx=2 for 15 cycles, then timeout=1 one cycle,
//     grant re-issued to 2 after GAP+IDLE.
//  T5 done vs timeout: assert done on the 15th BUSY cycle -> release, timeout stays 0.
//  T6 abort/reset: drop req[3] while granted -> GAP next cycle, timeout=0; assert rst in BUSY
//     -> outputs 0 asynchronously, next grant search starts from index 0.

Source files
------------

// File: rtl/rr_object_arbiter_if.sv
// Handshake bundle between the object FSMs and the shared-resource arbiter.
// master: drives req/done, sees grant side; slave: the arbiter itself.
interface rr_object_arbiter_if #(
   parameter int N_REQ = 8,
   parameter int IDX_W = 3
);
   logic [N_REQ-1:0] req;
   logic             done;
   logic [N_REQ-1:0] grant;
   logic [IDX_W-1:0] grant_idx;
   logic             grant_valid;
   logic             timeout;

   modport master (
      output req,
      output done,
      input  grant,
      input  grant_idx,
      input  grant_valid,
      input  timeout
   );

   modport slave (
      input  req,
      input  done,
      output grant,
      output grant_idx,
      output grant_valid,
      output timeout
   );
endinterface

// File: rtl/rr_object_arbiter.sv
// Round-robin arbiter for the shared object renderer / object RAM port.
// Ports: clk, rst (async, active-high), bus (slave: req, done -> grant,
// grant_idx, grant_valid, timeout). Cycle: IDLE -> BUSY -> GAP -> IDLE.
module rr_object_arbiter #(
   parameter int N_REQ    = 8,
   parameter int IDX_W    = 3,
   parameter int MAX_HOLD = 15,
   parameter int HOLD_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   rr_object_arbiter_if.slave bus
);

   if (N_REQ < 2 || N_REQ > 32) begin : g_bad_n
      $error("rr_object_arbiter: N_REQ out of range");
   end
   if ((2 ** IDX_W) < N_REQ) begin : g_bad_w
      $error("rr_object_arbiter: IDX_W too narrow");
   end
   if (MAX_HOLD < 1 || MAX_HOLD > (2 ** HOLD_W) - 1) begin : g_bad_h
      $error("rr_object_arbiter: MAX_HOLD out of range");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [N_REQ-1:0]  grant_q, grant_d;
   logic              valid_q, valid_d;
   logic              tout_q, tout_d;

   logic [N_REQ-1:0]  masked;
   logic [IDX_W-1:0]  pick;
   logic              pick_ok;
   logic              req_cur;
   logic              at_limit;
   logic              release_now;
   logic [IDX_W-1:0]  next_ptr;

   // Requests at or above the pointer win; otherwise wrap to the
   // lowest request overall. Descending scan leaves the lowest hit.
   always_comb begin
      masked  = '0;
      pick    = '0;
      pick_ok = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         masked[i] = bus.req[i] && (i >= int'(ptr_q));
      end
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (masked[i]) begin
            pick    = IDX_W'(i);
            pick_ok = 1'b1;
         end
      end
      if (!pick_ok) begin
         for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
               pick    = IDX_W'(i);
               pick_ok = 1'b1;
            end
         end
      end
   end

   // grant_q is one-hot on the owner, so this is req[owner].
   assign req_cur  = |(bus.req & grant_q);
   assign at_limit = (hold_q == HOLD_W'(MAX_HOLD - 1));
   assign release_now = bus.done || !req_cur || at_limit;
   assign next_ptr = (idx_q == IDX_W'(N_REQ - 1)) ?
                     '0 : idx_q + IDX_W'(1);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = '0;
      hold_d  = hold_q;
      grant_d = '0;
      valid_d = 1'b0;
      tout_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            hold_d = '0;
            if (pick_ok) begin
               state_d = BUSY;
               idx_d   = pick;
               grant_d = N_REQ'(1) << pick;
               valid_d = 1'b1;
            end
         end
         BUSY: begin
            if (hold_q != HOLD_W'(MAX_HOLD)) begin
               hold_d = hold_q + HOLD_W'(1);
            end
            if (release_now) begin
               state_d = GAP;
               // Pointer moves past the owner as it leaves, so the
               // next search in IDLE already sees the rotated value.
               ptr_d   = next_ptr;
               // done and abort take precedence over the hold limit.
               tout_d  = !bus.done && req_cur;
            end else begin
               idx_d   = idx_q;
               grant_d = grant_q;
               valid_d = 1'b1;
            end
         end
         GAP: begin
            state_d = IDLE;
            hold_d  = '0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         idx_q   <= '0;
         hold_q  <= '0;
         grant_q <= '0;
         valid_q <= 1'b0;
         tout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         hold_q  <= hold_d;
         grant_q <= grant_d;
         valid_q <= valid_d;
         tout_q  <= tout_d;
      end
   end

   assign bus.grant       = grant_q;
   assign bus.grant_idx   = idx_q;
   assign bus.grant_valid = valid_q;
   assign bus.timeout     = tout_q;

endmodule

// File: tb/tb_rr_object_arbiter.sv
// Bench for rr_object_arbiter: cycle model of grant ownership plus
// directed scenarios with literal expectations.
module tb_rr_object_arbiter;
   localparam int N = 8;
   localparam int MH = 15;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;

   rr_object_arbiter_if #(.N_REQ(N), .IDX_W(3)) bus ();

   rr_object_arbiter #(
      .N_REQ(N), .IDX_W(3), .MAX_HOLD(MH), .HOLD_W(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // model: owner (-1 = none), completed BUSY edges, cooldown edges
   int m_owner = -1;
   int m_held = 0;
   int m_cool = 0;
   int m_ptr = 0;
   bit m_to = 1'b0;
   int m_log[$];

   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            m_owner = -1; m_held = 0; m_cool = 0; m_ptr = 0; m_to = 0;
         end else begin
            m_to = 1'b0;
            if (m_owner >= 0) begin
               m_held++;
               if (bus.done || !bus.req[m_owner] || m_held == MH) begin
                  m_to = !bus.done && bus.req[m_owner];
                  m_ptr = (m_owner + 1) % N;
                  m_owner = -1;
                  m_cool = 1;
               end
            end else if (m_cool > 0) begin
               m_cool--;
            end else begin
               for (int j = 0; j < N; j++) begin
                  if (m_owner < 0 && bus.req[(m_ptr + j) % N]) begin
                     m_owner = (m_ptr + j) % N;
                  end
               end
               if (m_owner >= 0) begin
                  m_held = 0;
                  m_log.push_back(m_owner);
               end
            end
         end
         #1;
         chk("m_grant", bus.grant,
             (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
         chk("m_idx", bus.grant_idx,
             (m_owner >= 0) ? m_owner : 0);
         chk("m_valid", bus.grant_valid, m_owner >= 0);
         chk("m_timeout", bus.timeout, m_to);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_grant(input string nm, input int exp_idx,
                             output int n);
      n = 0;
      while (!bus.grant_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_valid"}, bus.grant_valid, 1);
      chk({nm, "_idx"}, bus.grant_idx, exp_idx);
   endtask

   task automatic serve();
      cyc(1);
      bus.done = 1'b1;
      cyc(1);
      bus.done = 1'b0;
   endtask

   int n;
   int blen;
   int exp_log[17] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 5, 1, 3, 2, 2, 3, 7, 3};

   initial begin
      rst = 1'b1;
      bus.req = 8'hFF;
      bus.done = 1'b0;
      // T1 reset
      cyc(3);
      chk("rst_grant", bus.grant, 0);
      chk("rst_valid", bus.grant_valid, 0);
      chk("rst_timeout", bus.timeout, 0);
      rst = 1'b0;
      cyc(1);
      chk("first_grant", bus.grant, 8'h01);
      // T2 rotation
      for (int i = 0; i < 9; i++) begin
         wait_grant("rot", i % N, n);
         if (i > 0) chk("rot_gap", n, 2);
         serve();
      end
      // T3 wrap/skip
      bus.req = 8'h20;
      wait_grant("t3a", 5, n);
      serve();
      bus.req = 8'b0000_1010;
      wait_grant("t3b", 1, n);
      serve();
      wait_grant("t3c", 3, n);
      serve();
      // T4 timeout
      bus.req = 8'h04;
      wait_grant("t4", 2, n);
      blen = 1;
      @(negedge clk);
      while (bus.grant_valid && blen < 40) begin
         blen++;
         @(negedge clk);
      end
      chk("t4_busy_len", blen, 15);
      chk("t4_timeout", bus.timeout, 1);
      cyc(1);
      chk("t4_to_pulse", bus.timeout, 0);
      wait_grant("t4_regrant", 2, n);
      // T5 done on the 15th BUSY cycle
      cyc(14);
      chk("t5_still", bus.grant_valid, 1);
      bus.done = 1'b1;
      cyc(1);
      chk("t5_valid", bus.grant_valid, 0);
      chk("t5_timeout", bus.timeout, 0);
      bus.done = 1'b0;
      // T6 abort
      bus.req = 8'h08;
      wait_grant("t6a", 3, n);
      bus.req = 8'h00;
      cyc(1);
      chk("t6_abort_valid", bus.grant_valid, 0);
      chk("t6_abort_to", bus.timeout, 0);
      bus.req = 8'h88;
      wait_grant("t6b", 7, n);
      cyc(1);
      #2 rst = 1'b1;
      #1;
      chk("arst_grant", bus.grant, 0);
      chk("arst_valid", bus.grant_valid, 0);
      chk("arst_idx", bus.grant_idx, 0);
      chk("arst_timeout", bus.timeout, 0);
      @(negedge clk);
      rst = 1'b0;
      wait_grant("t6c", 3, n);
      bus.req = 8'h00;
      cyc(3);
      chk("log_len", m_log.size(), 17);
      for (int i = 0; i < 17; i++) begin
         if (i < m_log.size()) chk("log_item", m_log[i], exp_log[i]);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
